i2c_tx_fifo: RTL
================

Name: i2c_tx_fifo

Overview:
Synchronous first-word-fall-through FIFO sitting directly downstream of the APB slave interface.
- Write side: driven by the APB interface's write-enable and write-data outputs (APB address 0x0).
- Read side: consumed by the I2C master core when it loads the next byte/word to shift out.
- EMPTY feeds the TX interrupt; the error flag feeds the slave-error return.
- The same block is instantiated a second time as the RX FIFO with the roles swapped.

Parameters:
DWIDTH, 32, data word width
DEPTH, 16, number of entries; must be a power of 2 and at least 2
AWIDTH, 4, pointer width = log2(DEPTH); derived, not overridden
AF_MARGIN, 2, ALMOST_FULL asserts when COUNT >= DEPTH-AF_MARGIN
AE_MARGIN, 2, ALMOST_EMPTY asserts when COUNT <= AE_MARGIN

Ports:
PCLK  in  1  clock
PRESETn  in  1  synchronous active-low reset (sampled on rising PCLK)
WR_EN  in  1  push DATA_IN at the clock edge
DATA_IN  in  DWIDTH  write data
RD_EN  in  1  pop head entry at the clock edge
DATA_OUT  out  DWIDTH  head entry, valid whenever EMPTY=0 (show-ahead)
CLEAR  in  1  synchronous flush plus clear of sticky errors
FULL  out  1  COUNT==DEPTH
EMPTY  out  1  COUNT==0
ALMOST_FULL  out  1  see AF_MARGIN
ALMOST_EMPTY  out  1  see AE_MARGIN
COUNT  out  AWIDTH+1  current occupancy, 0..DEPTH
OVERFLOW  out  1  sticky: write attempted while full and not popped the same cycle
UNDERFLOW  out  1  sticky: read attempted while empty
ERROR  out  1  OVERFLOW | UNDERFLOW

Behaviour:
- Clocking and reset: single clock PCLK. Reset is synchronous, active-low on PRESETn.
- Reset values: rd_ptr=0, wr_ptr=0, COUNT=0, EMPTY=1, ALMOST_EMPTY=1, FULL=0, ALMOST_FULL=0, OVERFLOW=0, UNDERFLOW=0.
  - Memory contents are not cleared; DATA_OUT is don't-care while EMPTY=1.
- Reset mid-operation: all in-flight state is discarded at that edge. Any WR_EN/RD_EN in the same cycle is ignored.
- Priority: PRESETn low > CLEAR > push/pop.
  - CLEAR resets pointers, COUNT and the sticky flags exactly like reset.
  - Push/pop in a CLEAR cycle is ignored.
- Storage: DEPTH x DWIDTH register array.
  - Write pointer and read pointer each wrap modulo DEPTH.
  - Occupancy is tracked in an explicit COUNT register of AWIDTH+1 bits.
- Accept rules:
  - push_ok = WR_EN & (!FULL | RD_EN)
  - pop_ok = RD_EN & !EMPTY
- Full + simultaneous read/write: both accepted, COUNT unchanged, no overflow.
- Empty + simultaneous read/write:
  - Write accepted and read rejected; COUNT becomes 1.
  - UNDERFLOW sets.
  - No bypass: the written word appears on DATA_OUT the following cycle.
- COUNT update: +1 on push_ok only, -1 on pop_ok only, unchanged otherwise.
- Flags are registered or derived combinationally from registered COUNT, so all are valid one cycle after the causing edge.
- Latency:
  - Write to visibility on DATA_OUT/!EMPTY is 1 cycle.
  - Pop takes effect at the edge; the next entry is on DATA_OUT immediately after.
- Sticky errors:
  - OVERFLOW sets on WR_EN & FULL & !RD_EN. The rejected write does not modify memory or pointers.
  - UNDERFLOW sets on RD_EN & EMPTY. Pointers are unchanged.
  - Both hold until CLEAR or reset.
- DATA_OUT = mem[rd_ptr] (combinational read of the array), so the APB side can return it in the same access cycle that asserts RD_EN.

Decomposition:
- Shared package i2c_pkg:
  - Default DWIDTH/DEPTH constants.
  - APB register address constants 0x0, 0x4, 0x8, 0xC.
  - Function for clog2 pointer width.
- One natural sub-module: i2c_fifo_mem, the DEPTH x DWIDTH register array with one write port and one async read port.
  - The top handles pointers, COUNT, flags and errors.

Test Plan:
- Reset then idle -> EMPTY=1, COUNT=0, FULL=0, ERROR=0. Repeat with PRESETn asserted mid-stream after 5 pushes -> COUNT=0 next cycle.
- Push 0x11..0x1F, 0x20 (16 words) -> FULL=1 and COUNT=16 after last edge; ALMOST_FULL=1 from COUNT=14. Pop 16 -> DATA_OUT sequence 0x11..0x20 in order, then EMPTY=1.
- When FULL, push 0xDEAD without read -> OVERFLOW=1, ERROR=1, COUNT=16, head still 0x11. CLEAR -> all flags 0, COUNT=0.
- When FULL, simultaneous WR_EN(0xBEEF)+RD_EN -> COUNT stays 16, no OVERFLOW. After 16 further pops the last word out is 0xBEEF (wrap-around check).
- When EMPTY, RD_EN alone -> UNDERFLOW=1, pointers unchanged. When EMPTY, WR_EN(0x55)+RD_EN -> COUNT=1, DATA_OUT=0x55 next cycle, UNDERFLOW=1.
- Random 2000-cycle push/pop mix against a queue scoreboard -> data order, COUNT and all flags match every cycle.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared constants and helpers for the I2C controller's APB-facing blocks.
package i2c_pkg;

  localparam int DEF_DWIDTH = 32;
  localparam int DEF_DEPTH  = 16;

  localparam logic [7:0] ADDR_TXDATA = 8'h00;
  localparam logic [7:0] ADDR_RXDATA = 8'h04;
  localparam logic [7:0] ADDR_STATUS = 8'h08;
  localparam logic [7:0] ADDR_CTRL   = 8'h0C;

  // Smallest width w with 2**w >= depth; callers guarantee depth >= 2.
  function automatic int ptr_width(input int depth);
    int w;
    w = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << w) < depth) w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/i2c_fifo_mem.sv
// FIFO storage: DEPTH x DWIDTH register array, one write port, one async read port.
module i2c_fifo_mem
  import i2c_pkg::*;
#(
  parameter int DWIDTH = DEF_DWIDTH,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int AWIDTH = ptr_width(DEF_DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AWIDTH-1:0] waddr,
  input  logic [DWIDTH-1:0] wdata,
  input  logic [AWIDTH-1:0] raddr,
  output logic [DWIDTH-1:0] rdata
);

  logic [DWIDTH-1:0] mem [DEPTH];

  // Contents are deliberately never reset; the head is don't-care while empty.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/i2c_tx_fifo.sv
// Show-ahead synchronous FIFO between the APB slave and the I2C core, with sticky
// overflow/underflow errors and occupancy-derived status flags.
module i2c_tx_fifo
  import i2c_pkg::*;
#(
  parameter int DWIDTH    = DEF_DWIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AF_MARGIN = 2,
  parameter int AE_MARGIN = 2,
  localparam int AWIDTH   = ptr_width(DEPTH)
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              WR_EN,
  input  logic [DWIDTH-1:0] DATA_IN,
  input  logic              RD_EN,
  output logic [DWIDTH-1:0] DATA_OUT,
  input  logic              CLEAR,
  output logic              FULL,
  output logic              EMPTY,
  output logic              ALMOST_FULL,
  output logic              ALMOST_EMPTY,
  output logic [AWIDTH:0]   COUNT,
  output logic              OVERFLOW,
  output logic              UNDERFLOW,
  output logic              ERROR
);

  localparam logic [AWIDTH:0] FULL_LEVEL = (AWIDTH + 1)'(DEPTH);
  localparam logic [AWIDTH:0] AF_LEVEL   = (AWIDTH + 1)'(DEPTH - AF_MARGIN);
  localparam logic [AWIDTH:0] AE_LEVEL   = (AWIDTH + 1)'(AE_MARGIN);

  logic [AWIDTH-1:0] wr_ptr;
  logic [AWIDTH-1:0] rd_ptr;
  logic [AWIDTH:0]   count_q;
  logic              overflow_q;
  logic              underflow_q;
  logic              push_ok;
  logic              pop_ok;
  logic              mem_we;

  // A full FIFO still accepts a write when the same cycle pops the head.
  assign push_ok = WR_EN & (~FULL | RD_EN);
  assign pop_ok  = RD_EN & ~EMPTY;
  assign mem_we  = push_ok & PRESETn & ~CLEAR;

  i2c_fifo_mem #(
    .DWIDTH (DWIDTH),
    .DEPTH  (DEPTH),
    .AWIDTH (AWIDTH)
  ) u_mem (
    .clk   (PCLK),
    .we    (mem_we),
    .waddr (wr_ptr),
    .wdata (DATA_IN),
    .raddr (rd_ptr),
    .rdata (DATA_OUT)
  );

  always_ff @(posedge PCLK) begin
    if (!PRESETn || CLEAR) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AWIDTH'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AWIDTH'(1);
      if (push_ok && !pop_ok)      count_q <= count_q + (AWIDTH + 1)'(1);
      else if (pop_ok && !push_ok) count_q <= count_q - (AWIDTH + 1)'(1);
      if (WR_EN && FULL && !RD_EN) overflow_q  <= 1'b1;
      if (RD_EN && EMPTY)          underflow_q <= 1'b1;
    end
  end

  assign COUNT        = count_q;
  assign FULL         = (count_q == FULL_LEVEL);
  assign EMPTY        = (count_q == '0);
  assign ALMOST_FULL  = (count_q >= AF_LEVEL);
  assign ALMOST_EMPTY = (count_q <= AE_LEVEL);
  assign OVERFLOW     = overflow_q;
  assign UNDERFLOW    = underflow_q;
  assign ERROR        = overflow_q | underflow_q;

endmodule
